// File: rtl/dcache_mem_pkg.sv
// Shared definitions for dcache_mem: micro-op codes, FSM states, access sizes
// and the uop decoder.
package dcache_pkg;

    localparam logic [4:0] UOP_STR   = 5'b01001;
    localparam logic [4:0] UOP_LDR   = 5'b01010;
    localparam logic [4:0] UOP_STRB  = 5'b01011;
    localparam logic [4:0] UOP_LDRB  = 5'b01100;
    localparam logic [4:0] UOP_LDRSB = 5'b01101;
    localparam logic [4:0] UOP_STRH  = 5'b01110;
    localparam logic [4:0] UOP_LDRH  = 5'b01111;
    localparam logic [4:0] UOP_LDRSH = 5'b10000;

    typedef enum logic {CLEAR, IDLE} state_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    typedef struct packed {
        size_e size;
        logic  sgn;
        logic  load;
        logic  store;
        logic  unknown;
    } uop_dec_t;

    function automatic uop_dec_t decode_uop(input logic [4:0] uop);
        uop_dec_t d;
        d.size    = SZ_W;
        d.sgn     = 1'b0;
        d.load    = 1'b0;
        d.store   = 1'b0;
        d.unknown = 1'b0;
        case (uop)
            UOP_STR:   d.store = 1'b1;
            UOP_LDR:   d.load  = 1'b1;
            UOP_STRB:  begin d.size = SZ_B; d.store = 1'b1; end
            UOP_LDRB:  begin d.size = SZ_B; d.load  = 1'b1; end
            UOP_LDRSB: begin d.size = SZ_B; d.load  = 1'b1; d.sgn = 1'b1; end
            UOP_STRH:  begin d.size = SZ_H; d.store = 1'b1; end
            UOP_LDRH:  begin d.size = SZ_H; d.load  = 1'b1; end
            UOP_LDRSH: begin d.size = SZ_H; d.load  = 1'b1; d.sgn = 1'b1; end
            default:   d.unknown = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dcache_mem_if.sv
// Request/response bundle between the execute stage and dcache_mem.
interface dcache_mem_if #(parameter int ADDR_W = 5) ();

    logic              req_valid;
    logic              req_ready;
    logic [4:0]        uop;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       data_in;
    logic              rsp_valid;
    logic [31:0]       data_out;
    logic              fault;
    logic              busy;

    modport master (
        output req_valid, uop, addr, data_in,
        input  req_ready, rsp_valid, data_out, fault, busy
    );

    modport slave (
        input  req_valid, uop, addr, data_in,
        output req_ready, rsp_valid, data_out, fault, busy
    );

endinterface

// File: rtl/dcache_mem_lane_align.sv
// Combinational byte-lane steering: load extraction with sign/zero extension
// and store merging of sub-word data into the old word.
module dcache_lane_align
    import dcache_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  size_e       size_i,
    input  logic        sgn_i,
    output logic [31:0] ld_data_o,
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] st_word_o
);

    logic [31:0] shifted;

    assign shifted = word_i >> {lane_i, 3'b000};

    always_comb begin
        ld_data_o = word_i;
        case (size_i)
            SZ_B:    ld_data_o = {{24{sgn_i & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data_o = {{16{sgn_i & shifted[15]}}, shifted[15:0]};
            default: ld_data_o = word_i;
        endcase
    end

    always_comb begin
        st_word_o = old_i;
        case (size_i)
            SZ_B:    st_word_o[{lane_i, 3'b000} +: 8]        = wdata_i[7:0];
            SZ_H:    st_word_o[{lane_i[1], 4'b0000} +: 16]  = wdata_i[15:0];
            default: st_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/dcache_mem.sv
// Parametrised data memory with byte/half/word loads and stores, a post-reset
// clear sequence and a single-cycle registered response.
module dcache_mem
    import dcache_pkg::*;
#(
    parameter  int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset_n,
    dcache_mem_if.slave  bus
);

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [31:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clear_idx_q, clear_idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              fault_q, fault_d;
    logic [31:0]       data_q, data_d;

    uop_dec_t          dec;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              in_range, misalign, bad, accept;
    logic [31:0]       rd_word, ld_word, st_word;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [31:0]       wd;

    assign dec      = decode_uop(bus.uop);
    assign idx      = bus.addr[ADDR_W+1:2];
    assign lane     = bus.addr[1:0];
    assign in_range = {1'b0, idx} < DEPTH_W;
    assign misalign = (dec.size == SZ_H && lane[0]) || (dec.size == SZ_W && lane != 2'b00);
    assign bad      = dec.unknown || misalign || !in_range;
    assign accept   = bus.req_valid && (state_q == IDLE);
    // Out-of-range indices never touch the array; the fault path discards the value.
    assign rd_word  = in_range ? mem_q[idx] : '0;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == CLEAR);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.data_out  = data_q;
    assign bus.fault     = fault_q;

    dcache_lane_align u_align (
        .word_i    (rd_word),
        .lane_i    (lane),
        .size_i    (dec.size),
        .sgn_i     (dec.sgn),
        .ld_data_o (ld_word),
        .old_i     (rd_word),
        .wdata_i   (bus.data_in),
        .st_word_o (st_word)
    );

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        rsp_valid_d = 1'b0;
        fault_d     = 1'b0;
        data_d      = '0;
        we          = 1'b0;
        wa          = clear_idx_q;
        wd          = '0;
        case (state_q)
            CLEAR: begin
                we          = 1'b1;
                clear_idx_d = clear_idx_q + 1'b1;
                if (clear_idx_q == LAST) begin
                    state_d     = IDLE;
                    clear_idx_d = '0;
                end
            end
            IDLE: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    if (bad) begin
                        fault_d = 1'b1;
                    end else if (dec.load) begin
                        data_d = ld_word;
                    end else if (dec.store) begin
                        we = 1'b1;
                        wa = idx;
                        wd = st_word;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            clear_idx_q <= '0;
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            rsp_valid_q <= rsp_valid_d;
            fault_q     <= fault_d;
            data_q      <= data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
    end

endmodule

// File: doc/dcache_mem.md
# dcache_mem

Parametrised data memory that succeeds the fixed 32×32 word-only data cache. It serves load/store micro-ops from the execute stage with byte, halfword and word access, sign/zero extension, alignment checking, a valid/ready request handshake and a registered response. After reset it clears its own storage through a sequential clear state machine. All activity is on the rising clock edge.

## Interface
- DEPTH, 32, number of 32-bit words; any value ≥ 2, not required to be a power of two
- ADDR_W, $clog2(DEPTH), word-index width; derived, not overridden
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block accepts a request this cycle
- uop  input  5  micro-op code, from dcache_pkg
- addr  input  ADDR_W+2  byte address; word index is addr[ADDR_W+1:2], byte lane is addr[1:0]
- data_in  input  32  store data, taken from the low bytes for byte and halfword stores
- rsp_valid  output  1  one-cycle response pulse
- data_out  output  32  load result; 0 for stores and faults
- fault  output  1  qualifies rsp_valid: misaligned address, out-of-range address or unknown uop
- busy  output  1  high while the clear state machine runs

## Operation
- Uop codes: STR 01001, LDR 01010, STRB 01011, LDRB 01100, LDRSB 01101, STRH 01110, LDRH 01111, LDRSH 10000. All other codes are unknown.
- Byte lanes are little-endian; lane n is bits [8n+7:8n].
- State machine states:
  - CLEAR: writes 0 to word clear_idx each cycle. clear_idx counts 0..DEPTH-1. On the cycle clear_idx == DEPTH-1, the state goes to IDLE.
  - IDLE: req_ready = 1.
- A request is accepted when req_valid && req_ready.
- Stores write on the accepting edge and update only the addressed lanes:
  - STRB writes one lane with data_in[7:0].
  - STRH writes lanes addr[1]*2 and addr[1]*2+1 with data_in[15:0].
  - STR writes the full word.
- Loads read the addressed word on the accepting edge.
  - LDRB / LDRH zero-extend.
  - LDRSB / LDRSH sign-extend.
  - LDR returns the full word.
- Fault conditions. Any fault means no write, fault = 1 and data_out = 0:
  - halfword op with addr[0] = 1
  - word op with addr[1:0] ≠ 0
  - word index ≥ DEPTH
  - unknown uop
- Responses:
  - Every accepted request produces exactly one response with rsp_valid = 1, one cycle after acceptance.
  - There is no response backpressure.
  - Stores respond with data_out = 0 and fault = 0.
- Store followed by a load of the same word on the next cycle returns the newly written data. No stale read is permitted.

## Timing
- Reset values (asynchronous, while reset_n = 0): state = CLEAR, clear_idx = 0, req_ready = 0, busy = 1, rsp_valid = 0, data_out = 0, fault = 0. Memory contents are undefined until the clear completes.
- Clear length: exactly DEPTH cycles after reset_n deasserts. busy falls and req_ready rises on the same edge that enters IDLE.
- Requests presented during CLEAR are not accepted, and req_valid must be held by the requester. The requester must not drop req_valid before acceptance.
- Throughput is one request per cycle in IDLE. Back-to-back requests give back-to-back rsp_valid pulses.
- Load latency is 1 cycle: data_out is registered and valid in the cycle after acceptance. data_out and fault are held at 0 whenever rsp_valid = 0.
- Reset asserted mid-operation: any in-flight response is dropped (rsp_valid goes to 0 immediately) and the clear restarts from index 0.
- Reset asserted mid-clear: the clear restarts from index 0.

## Structure
- Package dcache_pkg holds:
  - the uop code localparams above
  - the state enum {CLEAR, IDLE}
  - an access-size enum {SZ_B, SZ_H, SZ_W} with a decode function from uop to size, signedness, load/store and unknown
- Sub-module dcache_lane_align, purely combinational:
  - load side: word, lane, size, signed → extracted 32-bit result
  - store side: old word, data_in, lane, size → merged write word
- The top level holds the storage array, the state machine, the clear counter and the response registers.

## Test plan
- Reset with DEPTH = 32: busy = 1 for exactly 32 cycles. Then LDR of every word address returns 0 with fault = 0.
- STR 0x11223344 @0x8, then LDRB @0xB → 0x00000011, LDRSH @0xA → 0x00001122, LDR @0x8 → 0x11223344.
- STR 0x000000F0 @0x4, STRB 0x80 @0x5, then LDRSB @0x5 → 0xFFFFFF80 and LDR @0x4 → 0x000080F0.
- LDRH @0x3, STR 0xDEAD @0x2 and uop 00000 each produce fault = 1 and data_out = 0. A following LDR @0x0 shows the word unchanged.
- Back-to-back cycles STR 0xCAFEF00D @0x10 then LDR @0x10 → rsp_valid on two consecutive cycles, with the second returning 0xCAFEF00D.
- DEPTH = 20: LDR @0x50 → fault. reset_n pulsed low during an accepted LDR → no rsp_valid, busy for 20 cycles, and the memory reads 0 again.
